// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: one-entry pipeline register between fetch and execute.
// Decodes ALU fields, the sign-extended immediate and register indices, and flags illegal words.
module rv32_decode_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_opcode,
    output logic [2:0]      ex_func3,
    output logic            ex_func7,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_illegal
);

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [4:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } dec_t;

    dec_t       dec;
    dec_t       held;
    logic       accept;
    logic [31:0] i;
    logic [6:0]  f7;

    assign if_ready = !ex_valid || ex_ready;
    assign accept   = if_valid && if_ready;
    assign i        = if_inst;
    assign f7       = if_inst[31:25];

    always_comb begin
        dec         = '0;
        dec.opcode  = i[6:2];
        dec.func3   = i[14:12];
        dec.rd      = i[11:7];
        dec.rs1     = i[19:15];
        dec.illegal = (i[1:0] != 2'b11);
        case (i[6:2])
            OP_LUI, OP_AUIPC: begin
                dec.imm = {i[31:12], 12'b0};
                dec.rs1 = '0;
            end
            OP_JAL: begin
                dec.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                dec.rs1 = '0;
            end
            OP_JALR: begin
                dec.imm     = {{20{i[31]}}, i[31:20]};
                dec.illegal = dec.illegal || (i[14:12] != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                dec.rd      = '0;
                dec.rs2     = i[24:20];
                dec.illegal = dec.illegal || (i[14:12] == 3'b010) || (i[14:12] == 3'b011);
            end
            OP_LOAD: begin
                dec.imm     = {{20{i[31]}}, i[31:20]};
                dec.illegal = dec.illegal || (i[14:12] == 3'b011) || (i[14:13] == 2'b11);
            end
            OP_STORE: begin
                dec.imm     = {{20{i[31]}}, i[31:25], i[11:7]};
                dec.rd      = '0;
                dec.rs2     = i[24:20];
                dec.illegal = dec.illegal || (i[14:12] >= 3'b011);
            end
            OP_IMM: begin
                dec.imm = {{20{i[31]}}, i[31:20]};
                // only shifts carry an ALU qualifier; addi with a negative imm must not look like sub
                if (i[14:12] == 3'b001) begin
                    dec.func7   = i[30];
                    dec.illegal = dec.illegal || (f7 != 7'b0000000);
                end else if (i[14:12] == 3'b101) begin
                    dec.func7   = i[30];
                    dec.illegal = dec.illegal || !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                end
            end
            OP_OP: begin
                dec.rs2     = i[24:20];
                dec.func7   = i[30];
                dec.illegal = dec.illegal || !((f7 == 7'b0000000) || (f7 == 7'b0100000))
                            || (i[30] && !((i[14:12] == 3'b000) || (i[14:12] == 3'b101)));
            end
            OP_FENCE, OP_SYSTEM: begin
                dec.imm = {{20{i[31]}}, i[31:20]};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // rst beats flush, flush beats accept; data fields stay stale on flush/drain
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= RESET_PC;
            held     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_pc    <= if_pc;
            held     <= dec;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_opcode  = held.opcode;
    assign ex_func3   = held.func3;
    assign ex_func7   = held.func7;
    assign ex_imm     = held.imm;
    assign ex_rs1     = held.rs1;
    assign ex_rs2     = held.rs2;
    assign ex_rd      = held.rd;
    assign ex_illegal = held.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed decode table, handshake corner sequences,
// then random traffic against a format-level reference model.
module tb_rv32_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic        func7;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush, ex_valid, ex_ready;
    logic [31:0] if_pc, if_inst, ex_pc, ex_imm;
    logic [4:0]  ex_opcode, ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_func3;
    logic        ex_func7, ex_illegal;

    int nvec = 0;
    int nerr = 0;

    rv32_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_inst(if_inst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input exp_t e);
        chk($sformatf("%s.opcode", tag), 32'(ex_opcode), 32'(e.opcode));
        chk($sformatf("%s.func3", tag), 32'(ex_func3), 32'(e.func3));
        chk($sformatf("%s.func7", tag), 32'(ex_func7), 32'(e.func7));
        chk($sformatf("%s.imm", tag), ex_imm, e.imm);
        chk($sformatf("%s.rs1", tag), 32'(ex_rs1), 32'(e.rs1));
        chk($sformatf("%s.rs2", tag), 32'(ex_rs2), 32'(e.rs2));
        chk($sformatf("%s.rd", tag), 32'(ex_rd), 32'(e.rd));
        chk($sformatf("%s.illegal", tag), 32'(ex_illegal), 32'(e.illegal));
    endtask

    // Reference decoder: classify the format letter, then build fields from it.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        byte         fmt;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] sx;
        logic        shift;
        op = w[6:2];
        f3 = w[14:12];
        f7 = w[31:25];
        sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
        case (op)
            5'b01101, 5'b00101:                               fmt = "U";
            5'b11011:                                         fmt = "J";
            5'b11000:                                         fmt = "B";
            5'b01000:                                         fmt = "S";
            5'b01100:                                         fmt = "R";
            5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: fmt = "I";
            default:                                          fmt = "X";
        endcase
        e = '0;
        e.opcode = op;
        e.func3  = f3;
        case (fmt)
            "I": e.imm = (sx << 12) | 32'(w[31:20]);
            "S": e.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
            "B": e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            "U": e.imm = w & 32'hFFFF_F000;
            "J": e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: e.imm = 32'h0;
        endcase
        shift   = (op == 5'b00100) && (f3 == 3'd1 || f3 == 3'd5);
        e.func7 = (fmt == "R" || shift) ? w[30] : 1'b0;
        e.rd    = (fmt == "B" || fmt == "S") ? 5'd0 : w[11:7];
        e.rs1   = (fmt == "U" || fmt == "J") ? 5'd0 : w[19:15];
        e.rs2   = (fmt == "B" || fmt == "S" || fmt == "R") ? w[24:20] : 5'd0;
        e.illegal = (w[1:0] != 2'b11) || (fmt == "X");
        if (fmt == "R")
            e.illegal |= !(f7 inside {7'h00, 7'h20}) || (w[30] && !(f3 inside {3'd0, 3'd5}));
        if (op == 5'b00100 && f3 == 3'd1) e.illegal |= (f7 != 7'h00);
        if (op == 5'b00100 && f3 == 3'd5) e.illegal |= !(f7 inside {7'h00, 7'h20});
        if (op == 5'b11000) e.illegal |= (f3 inside {3'd2, 3'd3});
        if (op == 5'b00000) e.illegal |= (f3 inside {3'd3, 3'd6, 3'd7});
        if (op == 5'b01000) e.illegal |= (f3 >= 3'd3);
        if (op == 5'b11001) e.illegal |= (f3 != 3'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0]  ops [11];
        logic [31:0] w;
        int          k;
        ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:2] = ops[k];
        if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    vec_t tbl [13];
    logic        mv;
    logic [31:0] mpc;
    exp_t        md;

    initial begin
        // expected: opcode, func3, func7, imm, rs1, rs2, rd, illegal
        tbl[0]  = '{32'h40B50533, '{5'b01100, 3'd0, 1'b1, 32'h0000_0000, 5'd10, 5'd11, 5'd10, 1'b0}};
        tbl[1]  = '{32'hFFF00513, '{5'b00100, 3'd0, 1'b0, 32'hFFFF_FFFF, 5'd0,  5'd0,  5'd10, 1'b0}};
        tbl[2]  = '{32'h40055513, '{5'b00100, 3'd5, 1'b1, 32'h0000_0400, 5'd10, 5'd0,  5'd10, 1'b0}};
        tbl[3]  = '{32'hFE000EE3, '{5'b11000, 3'd0, 1'b0, 32'hFFFF_FFFC, 5'd0,  5'd0,  5'd0,  1'b0}};
        tbl[4]  = '{32'h0080006F, '{5'b11011, 3'd0, 1'b0, 32'h0000_0008, 5'd0,  5'd0,  5'd0,  1'b0}};
        tbl[5]  = '{32'h00000000, '{5'b00000, 3'd0, 1'b0, 32'h0000_0000, 5'd0,  5'd0,  5'd0,  1'b1}};
        tbl[6]  = '{32'h02000033, '{5'b01100, 3'd0, 1'b0, 32'h0000_0000, 5'd0,  5'd0,  5'd0,  1'b1}};
        tbl[7]  = '{32'h0000A063, '{5'b11000, 3'd2, 1'b0, 32'h0000_0000, 5'd1,  5'd0,  5'd0,  1'b1}};
        tbl[8]  = '{32'h123450B7, '{5'b01101, 3'd5, 1'b0, 32'h1234_5000, 5'd0,  5'd0,  5'd1,  1'b0}};
        tbl[9]  = '{32'hFEB52E23, '{5'b01000, 3'd2, 1'b0, 32'hFFFF_FFFC, 5'd10, 5'd11, 5'd0,  1'b0}};
        tbl[10] = '{32'h02051513, '{5'b00100, 3'd1, 1'b0, 32'h0000_0020, 5'd10, 5'd0,  5'd10, 1'b1}};
        tbl[11] = '{32'h40B51533, '{5'b01100, 3'd1, 1'b1, 32'h0000_0000, 5'd10, 5'd11, 5'd10, 1'b1}};
        tbl[12] = '{32'h00051067, '{5'b11001, 3'd1, 1'b0, 32'h0000_0000, 5'd10, 5'd0,  5'd0,  1'b1}};

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        if_pc = 32'h0; if_inst = 32'h0;
        step; step;
        chk("reset.valid", 32'(ex_valid), 32'd0);
        chk("reset.pc", ex_pc, RPC);
        chk("reset.imm", ex_imm, 32'h0);
        chk("reset.rd", 32'(ex_rd), 32'd0);
        rst = 1'b0;
        step;
        chk("post_reset.if_ready", 32'(if_ready), 32'd1);

        foreach (tbl[n]) begin
            if_valid = 1'b1; if_inst = tbl[n].inst; if_pc = 32'h1000 + 32'(n) * 4;
            step;
            if_valid = 1'b0;
            chk($sformatf("vec%0d.valid", n), 32'(ex_valid), 32'd1);
            chk($sformatf("vec%0d.pc", n), ex_pc, 32'h1000 + 32'(n) * 4);
            chk_dec($sformatf("vec%0d", n), tbl[n].e);
        end
        step;
        chk("drain.valid", 32'(ex_valid), 32'd0);

        // stall: A held three cycles while B waits, then A leaves and B enters together
        if_valid = 1'b1; if_inst = tbl[0].inst; if_pc = 32'h200; ex_ready = 1'b0;
        step;
        chk("stall.a_valid", 32'(ex_valid), 32'd1);
        if_inst = tbl[1].inst; if_pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall.if_ready", 32'(if_ready), 32'd0);
            step;
            chk("stall.valid", 32'(ex_valid), 32'd1);
            chk("stall.pc", ex_pc, 32'h200);
            chk_dec("stall", tbl[0].e);
        end
        ex_ready = 1'b1;
        #1 chk("unstall.if_ready", 32'(if_ready), 32'd1);
        step;
        chk("unstall.valid", 32'(ex_valid), 32'd1);
        chk("unstall.pc", ex_pc, 32'h204);
        chk_dec("unstall", tbl[1].e);

        // flush with a valid entry held and a valid word offered
        if_inst = tbl[3].inst; if_pc = 32'h208; flush = 1'b1;
        #1 chk("flush.if_ready", 32'(if_ready), 32'd1);
        step;
        flush = 1'b0; if_valid = 1'b0;
        chk("flush.valid", 32'(ex_valid), 32'd0);
        step;
        chk("flush.dropped", 32'(ex_valid), 32'd0);

        // reset (together with flush) in the middle of a stall
        if_valid = 1'b1; if_inst = tbl[1].inst; if_pc = 32'h300; ex_ready = 1'b0;
        step;
        chk("rst_stall.valid", 32'(ex_valid), 32'd1);
        rst = 1'b1; flush = 1'b1;
        step;
        chk("rst_stall.valid_clr", 32'(ex_valid), 32'd0);
        chk("rst_stall.pc", ex_pc, RPC);
        chk("rst_stall.imm", ex_imm, 32'h0);
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
        step;
        chk("rst_stall.if_ready", 32'(if_ready), 32'd1);

        // random traffic against the reference model
        mv = 1'b0; mpc = 32'h0; md = '0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd.valid", 32'(ex_valid), 32'(mv));
            if (mv) begin
                chk("rnd.pc", ex_pc, mpc);
                chk_dec("rnd", md);
            end
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 11) == 0);
            if_pc    = $urandom & 32'hFFFF_FFFC;
            if_inst  = gen_inst();
            #1 chk("rnd.if_ready", 32'(if_ready), 32'(!mv || ex_ready));
            if (flush) mv = 1'b0;
            else if (if_valid && (!mv || ex_ready)) begin
                mv = 1'b1; mpc = if_pc; md = model(if_inst);
            end else if (ex_ready) mv = 1'b0;
            step;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
